data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder on the far side of the MEM-stage store/load request. It accepts one access per handshake from the EXE/MEM pipeline register outputs (write enable, store/load size, ALU address, store data), writes byte lanes or reads a raw 32-bit word, and returns a response after a fixed, configurable latency. Read data is returned unextended; sign/zero extension stays in the WB stage. While an access is in flight, the block raises a stall so the pipeline holds MEM.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, 16..65536; ADDR_W = log2(DEPTH_WORDS).
- LATENCY, 1: cycles from request acceptance to response; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- req_ready  out  1  request accepted this cycle if req_valid is also 1.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  raw word for loads; 0 for stores and error responses.
- resp_err  out  1  misaligned or reserved-size request; drives WrongAddressinMEM.
- stall  out  1  req_valid & ~req_ready.

## Operation
- FSM has two states. IDLE: req_ready=1. BUSY: an access is pending, and cnt holds the remaining cycles.
- Accept = req_valid & req_ready at a rising edge.
- On accept: state <= BUSY, cnt <= LATENCY-1.
- If not an error:
  - A store commits its byte lanes at the accept edge.
  - A load captures mem[req_addr[ADDR_W+1:2]] at the accept edge.
- In BUSY: resp_valid = (cnt==0). If cnt!=0, cnt decrements each cycle.
- When cnt==0, req_ready=1, so a new request can be accepted in the same cycle as the response. With no accept, the next state is IDLE.
- Lane selection uses a = req_addr[1:0]:
  - byte: writes lane a (bits 8a+7:8a) with wdata[7:0].
  - half: writes lanes a[1]*2 and a[1]*2+1 with wdata[15:0].
  - word: writes all four lanes.
- Address index is req_addr[ADDR_W+1:2]. Upper bits are ignored, so the address space wraps modulo 4*DEPTH_WORDS.
- A store followed by a load to the same word: the load observes the new data, because the store commits at the earlier accept edge.
- resp_valid has no back-pressure; the consumer must take it the cycle it is asserted.

## Timing
- Request valid in cycle T and accepted → resp_valid, resp_rdata and resp_err are valid in cycle T+LATENCY only.
- req_ready is low in cycles T+1..T+LATENCY-1. With LATENCY=1, the block sustains one access per cycle.
- Reset values: state IDLE, cnt 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1, stall 0. RAM contents are not reset.
- Reset mid-operation drops the pending response; no resp_valid is produced. A store already accepted before reset stays committed.
- resp_rdata and resp_err hold their last values when resp_valid=0. Consumers qualify both with resp_valid.

## Configuration
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined, an error is flagged for any of:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size 11.
- On an error: no RAM write, resp_err=1, resp_rdata=0, and latency is unchanged.
- Undefined: resp_err is tied to 0 and size 11 is treated as word. Half ignores addr[0]; word ignores addr[1:0]. The access goes to the naturally aligned containing lanes.

## Test plan
- LATENCY=1: store word 0xDEADBEEF @0x10 in T, load @0x10 in T+1 → resp in T+2: rdata 0xDEADBEEF, err 0. Store response in T+1 has rdata 0.
- Lanes: word 0x11223344 @0x10; byte 0xAB @0x13 → load 0x10 returns 0xAB223344. Then half 0x5566 @0x10 → 0xAB225566.
- LATENCY=3, back-to-back loads held valid from T:
  - req_ready=0 and stall=1 in T+1 and T+2;
  - first resp_valid in T+3, second accepted in T+3;
  - second resp_valid in T+6; exactly two pulses.
- Word load @0x12:
  - with the macro → err=1, rdata 0; a store to @0x12 leaves 0x10 unchanged;
  - without the macro → returns the word at 0x10, err=0.
- LATENCY=3: store 0x0000CAFE @0x20 completes; load accepted in T, rst pulsed in T+1 → no resp_valid; req_ready=1 after release; reload @0x20 returns 0x0000CAFE.
- DEPTH_WORDS=1024: store 0x12345678 @0x1000 → load @0x0000 returns 0x12345678.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory load/store responder with fixed response latency.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned and reserved-size accesses via resp_err.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 1,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] pend_rdata, wdata_lanes, load_data;
  logic pend_err, accept, err, unused;
  logic [3:0] be;
  logic [1:0] a;
  logic [ADDR_W-1:0] idx;
  assign a = req_addr[1:0];
  assign idx = req_addr[ADDR_W+1:2];
  assign unused = ^req_addr[31:ADDR_W+2];
`ifdef DMEM_MISALIGN_CHECK_EN
  assign err = (req_size == 2'b11) | (req_size == 2'b01 & a[0]) | (req_size == 2'b10 & a != 2'b00);
`else
  assign err = 1'b0;
`endif
  assign be = req_size == 2'b00 ? 4'b0001 << a : req_size == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_lanes = req_size == 2'b00 ? {4{req_wdata[7:0]}} : req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign load_data = (req_wr | err) ? 32'h0 : mem[idx];
  assign req_ready = state == IDLE | cnt == 3'd0;
  assign resp_valid = state == BUSY & cnt == 3'd0;
  assign stall = req_valid & ~req_ready;
  assign accept = req_valid & req_ready;
  always_comb begin
    state_nx = accept ? BUSY : (state == BUSY && cnt != 3'd0) ? BUSY : IDLE;
    cnt_nx = accept ? 3'(LATENCY - 1) : cnt != 3'd0 ? cnt - 3'd1 : 3'd0;
  end
  // RAM is not reset; writes are suppressed while rst is asserted
  always_ff @(posedge clk)
    if (accept & req_wr & ~err & ~rst)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
  // response regs change only on the edge entering the response cycle, so they hold otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      pend_rdata <= 32'h0;
      pend_err <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        pend_rdata <= load_data;
        pend_err <= err;
      end
      if (accept && LATENCY == 1) begin
        resp_rdata <= load_data;
        resp_err <= err;
      end else if (state == BUSY && cnt == 3'd1) begin
        resp_rdata <= pend_rdata;
        resp_err <= pend_err;
      end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench with a LATENCY=1 and a LATENCY=3 instance.
module tb_data_mem_responder;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic v1 = 0, wr1 = 0, v3 = 0, wr3 = 0;
  logic [1:0] sz1 = 0, sz3 = 0;
  logic [31:0] ad1 = 0, wd1 = 0, ad3 = 0, wd3 = 0;
  logic ready1, rv1, err1, stall1, ready3, rv3, err3, stall3;
  logic [31:0] rd1, rd3;
  logic [32:0] q1 [$];
  logic [32:0] q3 [$];
  int checks = 0, errors = 0, pulses3 = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_wr(wr1), .req_size(sz1), .req_addr(ad1),
    .req_wdata(wd1), .req_ready(ready1), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .stall(stall1));
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_wr(wr3), .req_size(sz3), .req_addr(ad3),
    .req_wdata(wd3), .req_ready(ready3), .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3), .stall(stall3));

  always @(negedge clk) if (rv1) begin
    logic [32:0] e;
    checks++;
    if (q1.size() == 0) begin
      errors++;
      $display("FAIL resp1_unexpected got err=%b rdata=%h want no response", err1, rd1);
    end else begin
      e = q1.pop_front();
      if ({err1, rd1} !== e) begin
        errors++;
        $display("FAIL resp1_data got err=%b rdata=%h want err=%b rdata=%h", err1, rd1, e[32], e[31:0]);
      end
    end
  end

  always @(negedge clk) if (rv3) begin
    logic [32:0] e;
    pulses3++;
    checks++;
    if (q3.size() == 0) begin
      errors++;
      $display("FAIL resp3_unexpected got err=%b rdata=%h want no response", err3, rd3);
    end else begin
      e = q3.pop_front();
      if ({err3, rd3} !== e) begin
        errors++;
        $display("FAIL resp3_data got err=%b rdata=%h want err=%b rdata=%h", err3, rd3, e[32], e[31:0]);
      end
    end
  end

  task automatic req1(input logic wr, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd, input logic [32:0] exp);
    v1 = 1; wr1 = wr; sz1 = sz; ad1 = addr; wd1 = wd;
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b1) begin
      errors++;
      $display("FAIL req1_ready got %b want 1", ready1);
    end else q1.push_back(exp);
    @(posedge clk); #1 v1 = 0;
  endtask

  task automatic req3(input logic wr, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd, input logic [32:0] exp);
    int n = 0;
    v3 = 1; wr3 = wr; sz3 = sz; ad3 = addr; wd3 = wd;
    @(negedge clk);
    while (ready3 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (ready3 !== 1'b1) begin
      errors++;
      $display("FAIL req3_timeout got ready=%b want 1", ready3);
    end else q3.push_back(exp);
    @(posedge clk); #1 v3 = 0;
  endtask

  task automatic drain3;
    int n = 0;
    while (q3.size() != 0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (q3.size() != 0) begin
      errors++;
      $display("FAIL drain3_timeout got %0d pending want 0", q3.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready1, rv1, rd1, err1, stall1} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_u1 got ready=%b valid=%b rdata=%h err=%b stall=%b want 1 0 0 0 0", ready1, rv1, rd1, err1, stall1);
    end
    checks++;
    if ({ready3, rv3, rd3, err3, stall3} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_u3 got ready=%b valid=%b rdata=%h err=%b stall=%b want 1 0 0 0 0", ready3, rv3, rd3, err3, stall3);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_store_load;
    req1(1, 2'b10, 32'h10, 32'hDEADBEEF, {1'b0, 32'h0});
    req1(0, 2'b10, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF});
  endtask

  task automatic test_lanes;
    req1(1, 2'b10, 32'h10, 32'h11223344, 33'h0);
    req1(1, 2'b00, 32'h13, 32'hFFFFFFAB, 33'h0);
    req1(0, 2'b10, 32'h10, 32'h0, {1'b0, 32'hAB223344});
    req1(1, 2'b01, 32'h10, 32'hFFFF5566, 33'h0);
    req1(0, 2'b10, 32'h10, 32'h0, {1'b0, 32'hAB225566});
    req1(1, 2'b00, 32'h11, 32'h00000077, 33'h0);
    req1(1, 2'b01, 32'h12, 32'h00009999, 33'h0);
    req1(0, 2'b10, 32'h10, 32'h0, {1'b0, 32'h99997766});
  endtask

  task automatic test_misalign;
    req1(1, 2'b10, 32'h10, 32'h01020304, 33'h0);
    req1(0, 2'b10, 32'h12, 32'h0, CHK ? {1'b1, 32'h0} : {1'b0, 32'h01020304});
    req1(1, 2'b10, 32'h12, 32'hFFFFFFFF, CHK ? {1'b1, 32'h0} : 33'h0);
    req1(0, 2'b10, 32'h10, 32'h0, {1'b0, CHK ? 32'h01020304 : 32'hFFFFFFFF});
    req1(0, 2'b11, 32'h10, 32'h0, CHK ? {1'b1, 32'h0} : {1'b0, CHK ? 32'h01020304 : 32'hFFFFFFFF});
  endtask

  task automatic test_wrap;
    req1(1, 2'b10, 32'h1000, 32'h12345678, 33'h0);
    req1(0, 2'b10, 32'h0000, 32'h0, {1'b0, 32'h12345678});
  endtask

  task automatic test_back_to_back;
    int p0;
    req3(1, 2'b10, 32'h20, 32'h0000CAFE, 33'h0);
    req3(1, 2'b10, 32'h24, 32'h0000A5A5, 33'h0);
    drain3();
    p0 = pulses3;
    v3 = 1; wr3 = 0; sz3 = 2'b10; ad3 = 32'h20;
    @(negedge clk);
    checks++;
    if (ready3 !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b want 1", ready3); end
    q3.push_back({1'b0, 32'h0000CAFE});
    @(posedge clk); #1 ad3 = 32'h24;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if ({ready3, stall3, rv3} !== 3'b010) begin
        errors++;
        $display("FAIL b2b_busy_T+%0d got ready=%b stall=%b valid=%b want 0 1 0", k, ready3, stall3, rv3);
      end
    end
    @(negedge clk);
    checks++;
    if ({rv3, ready3} !== 2'b11) begin errors++; $display("FAIL b2b_T+3 got valid=%b ready=%b want 1 1", rv3, ready3); end
    q3.push_back({1'b0, 32'h0000A5A5});
    @(posedge clk); #1 v3 = 0;
    for (int k = 4; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (rv3 !== 1'b0) begin errors++; $display("FAIL b2b_T+%0d got valid=%b want 0", k, rv3); end
    end
    @(negedge clk);
    checks++;
    if (rv3 !== 1'b1) begin errors++; $display("FAIL b2b_T+6 got valid=%b want 1", rv3); end
    repeat (3) @(negedge clk);
    checks++;
    if (pulses3 - p0 != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses3 - p0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    v3 = 1; wr3 = 0; sz3 = 2'b10; ad3 = 32'h20;
    @(negedge clk);
    checks++;
    if (ready3 !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", ready3); end
    @(posedge clk); #1 v3 = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rv3, ready3} !== 2'b01) begin
        errors++;
        $display("FAIL rst_mid_idle got valid=%b ready=%b want 0 1", rv3, ready3);
      end
    end
    @(posedge clk); #1;
    req3(0, 2'b10, 32'h20, 32'h0, {1'b0, 32'h0000CAFE});
    drain3();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_lanes();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    repeat (5) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL missing_responses got %0d/%0d pending want 0/0", q1.size(), q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
